avalon_onchip_ram_dp: RTL and testbench
=======================================

AVALON_ONCHIP_RAM_DP -- requirements
Module: avalon_onchip_ram_dp

Interface
REQ-001 Parameter DATA_W, default 32, shall set the data width per port; it shall be a multiple of 8 and at most 128.
REQ-002 Parameter ADDR_W, default 14, shall set the word-address width; depth shall be 2**ADDR_W words.
REQ-003 Parameter RD_LATENCY, default 1, shall set the read latency in cycles; only the values 1 and 2 shall be legal.
REQ-004 Parameter INIT_FILE, default "onchip_ram.hex", shall name the power-up content file; an empty string shall mean undefined content.
REQ-005 clk  in  1  shall be the single clock for both ports and all state.
REQ-006 reset_n  in  1  shall be an asynchronous, active-low reset.
REQ-007 clken  in  1  shall be the global clock enable; when low, no access is accepted.
REQ-008 reset_req  in  1  shall be the reset-request input; when high, no access is accepted.
REQ-009 For each port p in {a,b}, p_address  in  ADDR_W  shall be the word address.
REQ-010 p_chipselect, p_read and p_write  in  1 each  shall be the Avalon-MM command qualifiers.
REQ-011 p_byteenable  in  DATA_W/8  shall be the byte lanes to write.
REQ-012 p_writedata  in  DATA_W  shall be the write data.
REQ-013 p_readdata  out  DATA_W  shall be the read data.
REQ-014 p_readdatavalid  out  1  shall mark p_readdata as valid.
REQ-015 p_waitrequest  out  1  shall stall the master.

Function
REQ-016 p_waitrequest shall be the combinational value ~clken | reset_req, identical on both ports.
REQ-017 An access on port p shall be accepted in a cycle where p_chipselect=1 and p_waitrequest=0; a command presented in any other cycle shall be ignored.
REQ-018 An accepted write shall update exactly the bytes selected by p_byteenable at the next clk edge.
REQ-019 An accepted cycle with p_read=1 and p_write=1 shall be treated as a write only, and shall produce no readdatavalid.
REQ-020 An accepted read in cycle N shall assert p_readdatavalid for exactly one cycle at cycle N+RD_LATENCY, with p_readdata valid in that same cycle.
REQ-021 Back-to-back reads shall be fully pipelined at one read per cycle per port, with responses returned in issue order.
REQ-022 Read pipeline contents shall keep advancing while p_waitrequest=1, so that responses to already-accepted reads are never lost or delayed.
REQ-023 p_readdata shall hold its last value when p_readdatavalid=0.
REQ-024 A read on one port of an address written by the other port in the same accepted cycle shall return the old data.
REQ-025 Same-port read-after-write to the same address in the next cycle shall return the new data.
REQ-026 When both ports write the same address in the same cycle, each byte enabled on port a shall take a's data and each byte enabled only on port b shall take b's data.
REQ-027 Reads and writes on the two ports to different addresses shall be fully independent.
REQ-028 An address shall be treated modulo the depth, so no address value is illegal.
REQ-029 The memory array shall be inferable as true-dual-port block RAM, with the output register used when RD_LATENCY=2; REQ-024 and REQ-026 shall be met by explicit logic.

Reset
REQ-030 While reset_n=0: p_readdatavalid=0, p_readdata=0 and all read-pipeline valid bits shall be cleared, asynchronously.
REQ-031 Reset shall not alter memory contents; writes shall be blocked while reset_n=0.
REQ-032 A read in flight when reset_n falls shall never produce a readdatavalid, including after reset is released.
REQ-033 The first access accepted after reset_n rises shall behave as per REQ-017 to REQ-020.

Verification
REQ-034 Write 0xDEADBEEF to address 5 on port a with byteenable=0xF, then write 0x000000AA with byteenable=0x1 -> port b read of address 5 returns 0xDEADBEAA after RD_LATENCY cycles.
REQ-035 Same-cycle writes to address 9: a writes 0x11111111 with byteenable=0x3, b writes 0x22222222 with byteenable=0xE -> read of address 9 returns 0x22221111.
REQ-036 Address 3 holds 0x0; port a writes 0x55 to address 3 while port b reads address 3 in the same cycle -> b returns 0x0; a b read in the next cycle returns 0x55.
REQ-037 With RD_LATENCY=2, issue 4 back-to-back reads on port a and drop clken after the 2nd -> reads 3 and 4 stall; responses 1 and 2 arrive 2 cycles after issue; exactly 4 readdatavalid pulses occur in total.
REQ-038 Issue a read, then assert reset_n=0 one cycle later -> no readdatavalid occurs; memory content written before reset is read back intact after reset.
REQ-039 Assert reset_req=1 with p_chipselect=1 and p_write=1 -> waitrequest=1 on both ports and memory is unchanged.

Source files
------------

// File: rtl/avalon_onchip_ram_dp_if.sv
// avalon_onchip_ram_dp_if: one Avalon-MM slave port of the dual-port on-chip RAM
interface avalon_onchip_ram_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;
  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );
  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_onchip_ram_dp.sv
// avalon_onchip_ram_dp: true-dual-port on-chip RAM with two Avalon-MM slave ports, pipelined
// reads of latency 1 or 2, read-old-data across ports and port-a byte priority on write collisions.
module avalon_onchip_ram_dp #(
  parameter int    DATA_W     = 32,
  parameter int    ADDR_W     = 14,
  parameter int    RD_LATENCY = 1,
  parameter string INIT_FILE  = "onchip_ram.hex"
) (
  input logic                   clk,
  input logic                   reset_n,
  input logic                   clken,
  input logic                   reset_req,
  avalon_onchip_ram_dp_if.slave a,
  avalon_onchip_ram_dp_if.slave b
);
  localparam int BE_W = DATA_W / 8;
  logic                stall;
  logic [1:0]          acc;
  logic [1:0]          wr;
  logic [1:0]          rd;
  logic [ADDR_W-1:0]   addr  [2];
  logic [BE_W-1:0]     be    [2];
  logic [DATA_W-1:0]   wdata [2];
  logic [DATA_W-1:0]   q1    [2];
  logic [DATA_W-1:0]   rdata [2];
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   mem   [2**ADDR_W];
  assign stall = ~clken | reset_req;
  assign acc   = {b.chipselect, a.chipselect} & {2{~stall & reset_n}};
  assign wr    = acc & {b.write, a.write};
  assign rd    = acc & {b.read, a.read} & ~{b.write, a.write};
  assign addr[0]  = a.address;
  assign addr[1]  = b.address;
  assign wdata[0] = a.writedata;
  assign wdata[1] = b.writedata;
  assign be[0]    = a.byteenable;
  // On a same-address collision port b only keeps the lanes port a leaves untouched
  assign be[1]    = b.byteenable & ~((wr[0] && a.address == b.address) ? a.byteenable : '0);
  // Reads sample the array before this edge's writes land, giving old data across ports
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < BE_W; i++)
        if (wr[p] && be[p][i]) mem[addr[p]][8*i +: 8] <= wdata[p][8*i +: 8];
      if (rd[p]) q1[p] <= mem[addr[p]];
    end
  end
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic              v1;
    logic              v2;
    logic              hd;
    logic [DATA_W-1:0] q2;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        hd <= 1'b0;
        q2 <= '0;
      end else begin
        v1 <= rd[p];
        v2 <= v1;
        hd <= hd | v1;
        if (v1) q2 <= q1[p];
      end
    // hd masks the unresettable RAM register so readdata reads zero until a response follows reset
    assign rvalid[p] = (RD_LATENCY == 2) ? v2 : v1;
    assign rdata[p]  = (RD_LATENCY == 2) ? q2 : ((hd | v1) ? q1[p] : '0);
  end
  assign a.waitrequest   = stall;
  assign b.waitrequest   = stall;
  assign a.readdata      = rdata[0];
  assign b.readdata      = rdata[1];
  assign a.readdatavalid = rvalid[0];
  assign b.readdatavalid = rvalid[1];
endmodule

// File: tb/tb_avalon_onchip_ram_dp.sv
// tb_avalon_onchip_ram_dp: drives a latency-1 and a latency-2 instance with identical traffic and
// checks every response, its arrival cycle and the held readdata against a scoreboard.
module tb_avalon_onchip_ram_dp;
  localparam int DW = 32;
  localparam int AW = 6;
  typedef struct packed {
    logic          cs;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] d;
  } cmd_t;
  typedef struct {
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  logic want_rst_n = 1'b0;
  logic want_clken = 1'b1;
  logic want_req = 1'b0;
  cmd_t cur_a;
  cmd_t cur_b;
  exp_t sb [4][$];
  logic [DW-1:0] last [4];
  logic [DW-1:0] model [int];
  logic [3:0] rv;
  logic [DW-1:0] rdd [4];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int fails = 0;
  int pulses = 0;
  always #5 clk = ~clk;
  avalon_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) a1 ();
  avalon_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();
  avalon_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) a2 ();
  avalon_onchip_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) b2 ();
  avalon_onchip_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .a(a1), .b(b1));
  avalon_onchip_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_LATENCY(2), .INIT_FILE("")) dut2 (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .a(a2), .b(b2));
  assign {a1.chipselect, a1.read, a1.write, a1.address, a1.byteenable, a1.writedata} = cur_a;
  assign {a2.chipselect, a2.read, a2.write, a2.address, a2.byteenable, a2.writedata} = cur_a;
  assign {b1.chipselect, b1.read, b1.write, b1.address, b1.byteenable, b1.writedata} = cur_b;
  assign {b2.chipselect, b2.read, b2.write, b2.address, b2.byteenable, b2.writedata} = cur_b;
  assign rv = {b2.readdatavalid, a2.readdatavalid, b1.readdatavalid, a1.readdatavalid};
  assign rdd[0] = a1.readdata;
  assign rdd[1] = b1.readdata;
  assign rdd[2] = a2.readdata;
  assign rdd[3] = b2.readdata;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic cmd_t mk(input logic cs, input logic rd, input logic wr, input int ad,
                              input logic [3:0] be, input logic [DW-1:0] d);
    logic [AW-1:0] a;
    a = ad[AW-1:0];
    return {cs, rd, wr, a, be, d};
  endfunction
  function automatic cmd_t rdc(input int ad);
    return mk(1'b1, 1'b1, 1'b0, ad, 4'h0, '0);
  endfunction
  function automatic cmd_t wrc(input int ad, input logic [3:0] be, input logic [DW-1:0] d);
    return mk(1'b1, 1'b0, 1'b1, ad, be, d);
  endfunction
  function automatic void mwrite(input cmd_t c);
    logic [DW-1:0] w;
    w = model.exists(int'(c.addr)) ? model[int'(c.addr)] : 'x;
    for (int i = 0; i < 4; i++)
      if (c.be[i]) w[8*i +: 8] = c.d[8*i +: 8];
    model[int'(c.addr)] = w;
  endfunction
  task automatic push_rd(input cmd_t c, input int k);
    if (c.cs && c.rd && !c.wr) begin
      sb[k].push_back('{model[int'(c.addr)], cyc + 1});
      sb[k+2].push_back('{model[int'(c.addr)], cyc + 2});
    end
  endtask
  task automatic step(input cmd_t ca, input cmd_t cb);
    @(negedge clk);
    if (reset_n && !want_rst_n)
      for (int k = 0; k < 4; k++) begin
        sb[k].delete();
        last[k] = '0;
      end
    reset_n = want_rst_n;
    clken = want_clken;
    reset_req = want_req;
    cur_a = ca;
    cur_b = cb;
    #1;
    chk("waitrequest", {a1.waitrequest, b1.waitrequest, a2.waitrequest, b2.waitrequest},
        {4{~clken | reset_req}});
    if (!reset_n) begin
      chk("reset_valid", rv, '0);
      chk("reset_readdata", rdd[0] | rdd[1] | rdd[2] | rdd[3], '0);
    end
    if (clken && !reset_req && reset_n) begin
      push_rd(ca, 0);
      push_rd(cb, 1);
      if (cb.cs && cb.wr) mwrite(cb);
      if (ca.cs && ca.wr) mwrite(ca);
    end
  endtask
  always @(posedge clk) begin
    bit due;
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      due = sb[k].size() > 0 && sb[k][0].cyc == cyc;
      if (k == 2 && rv[k]) pulses++;
      if (rv[k] || due) begin
        chk($sformatf("readdatavalid[%0d]", k), rv[k], due);
        if (due) begin
          chk($sformatf("readdata[%0d]", k), rdd[k], sb[k][0].d);
          last[k] = sb[k][0].d;
          void'(sb[k].pop_front());
        end
      end else chk($sformatf("readdata_hold[%0d]", k), rdd[k], last[k]);
    end
  end
  initial begin
    cmd_t idle;
    idle = '0;
    cur_a = '0;
    cur_b = '0;
    for (int k = 0; k < 4; k++) last[k] = '0;
    #1 reset_n = 1'b0;
    repeat (2) step(idle, idle);
    want_rst_n = 1'b1;
    step(idle, idle);
    step(wrc(5, 4'hF, 32'hDEADBEEF), idle);
    step(wrc(5, 4'h1, 32'h000000AA), idle);
    step(rdc(5), rdc(5));
    step(wrc(9, 4'h3, 32'h11111111), wrc(9, 4'hE, 32'h22222222));
    step(rdc(9), rdc(9));
    step(wrc(3, 4'hF, 32'h0), idle);
    step(wrc(3, 4'hF, 32'h55), rdc(3));
    step(idle, rdc(3));
    step(idle, wrc(7, 4'hF, 32'h12345678));
    step(idle, rdc(7));
    step(mk(1'b1, 1'b1, 1'b1, 10, 4'hF, 32'h0000ABCD), idle);
    step(rdc(10), idle);
    step(mk(1'b0, 1'b0, 1'b1, 5, 4'hF, 32'h0BADF00D), mk(1'b0, 1'b1, 1'b0, 5, 4'h0, '0));
    step(wrc(20, 4'hF, 32'hA0A0A0A0), wrc(21, 4'hF, 32'hB1B1B1B1));
    step(rdc(21), rdc(20));
    for (int i = 0; i < 8; i++) step(wrc(32 + i, 4'hF, $urandom), idle);
    for (int i = 0; i < 8; i++) step(rdc(32 + i), rdc(39 - i));
    repeat (3) step(idle, idle);
    pulses = 0;
    step(rdc(32), idle);
    step(rdc(33), idle);
    want_clken = 1'b0;
    repeat (3) step(rdc(34), idle);
    want_clken = 1'b1;
    step(rdc(34), idle);
    step(rdc(35), idle);
    repeat (4) step(idle, idle);
    chk("stall_pulses", pulses, 4);
    step(wrc(40, 4'hF, 32'hCAFE0000), idle);
    step(rdc(40), rdc(5));
    want_rst_n = 1'b0;
    step(idle, idle);
    step(wrc(40, 4'hF, 32'hFFFFFFFF), wrc(5, 4'hF, 32'hFFFFFFFF));
    step(idle, idle);
    want_rst_n = 1'b1;
    step(idle, idle);
    step(rdc(40), rdc(5));
    want_req = 1'b1;
    step(wrc(40, 4'hF, 32'h0), wrc(9, 4'hF, 32'h0));
    want_req = 1'b0;
    step(rdc(9), rdc(40));
    repeat (4) step(idle, idle);
    for (int k = 0; k < 4; k++) chk($sformatf("drained[%0d]", k), sb[k].size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
